audio_dac_out: RTL

AUDIO_DAC_OUT -- requirements
Module: audio_dac_out

---
 rtl/audio_pkg.sv | 18 +
 rtl/sd_modulator.sv | 30 +++
 rtl/audio_dac_out.sv | 91 +++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared constants for the audio output path: sample width, output mode
// encodings and the midscale (silence) level in offset-binary form.
package audio_pkg;

    localparam int SAMPLE_BITS = 8;
    localparam int FRAME_LOG2  = SAMPLE_BITS;

    localparam logic MODE_PWM = 1'b0;
    localparam logic MODE_SD  = 1'b1;

    localparam logic [SAMPLE_BITS-1:0] MIDSCALE = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

    // Two's-complement to offset binary: flipping the sign bit maps -max..max onto 0..full.
    function automatic logic [SAMPLE_BITS-1:0] to_offset(input logic [SAMPLE_BITS-1:0] s);
        return s ^ MIDSCALE;
    endfunction

endpackage

// File: rtl/sd_modulator.sv
// First-order sigma-delta accumulator: bit_out is the carry of acc + din,
// so the density of ones equals din / 2**WIDTH.
module sd_modulator #(
    parameter int WIDTH = audio_pkg::SAMPLE_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic             bit_out
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;

    assign sum     = {1'b0, acc} + {1'b0, din};
    assign bit_out = sum[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/audio_dac_out.sv
// 1-bit audio DAC output stage: frame counter, double-buffered sample
// register, PWM compare and a sigma-delta alternative, selected per frame.
module audio_dac_out #(
    parameter int SAMPLE_BITS = audio_pkg::SAMPLE_BITS,
    parameter int FRAME_LOG2  = audio_pkg::FRAME_LOG2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SAMPLE_BITS-1:0] sample_in,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    input  logic                   mode,
    output logic                   dac_out,
    output logic                   frame_start,
    output logic                   underrun
);

    import audio_pkg::*;

    localparam logic [SAMPLE_BITS-1:0] MSB_MASK = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
    localparam logic [FRAME_LOG2-1:0]  CNT_ONE  = {{(FRAME_LOG2-1){1'b0}}, 1'b1};
    localparam logic [FRAME_LOG2-1:0]  CNT_LAST = {FRAME_LOG2{1'b1}};

    logic [FRAME_LOG2-1:0]  cnt;
    logic [SAMPLE_BITS-1:0] pending;
    logic [SAMPLE_BITS-1:0] active;
    logic                   pend_full;
    logic                   mode_q;
    logic                   frame_end;
    logic                   transfer;
    logic                   sd_bit;
    logic                   sd_clear;
    logic                   sd_en;

    // Handshake: a sample moves only in a cycle where sample_valid and
    // sample_ready are both high; a producer holds sample_in steady while
    // valid is high and ready is low. Ready reopens on the last frame cycle
    // because the pending slot empties into active on that same edge.
    assign frame_end    = (cnt == CNT_LAST);
    assign sample_ready = !pend_full || frame_end;
    assign transfer     = sample_valid && sample_ready;
    assign frame_start  = rst_n && (cnt == '0);

    assign sd_clear = frame_end && (mode != mode_q);
    assign sd_en    = (mode_q == MODE_SD);

    sd_modulator #(
        .WIDTH (SAMPLE_BITS)
    ) u_sd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (sd_clear),
        .en      (sd_en),
        .din     (active),
        .bit_out (sd_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            pending   <= '0;
            pend_full <= 1'b0;
            active    <= MSB_MASK;
            mode_q    <= MODE_PWM;
            underrun  <= 1'b0;
            dac_out   <= 1'b0;
        end else begin
            cnt      <= cnt + CNT_ONE;
            underrun <= frame_end && !pend_full;

            // Active and mode only change at the frame boundary, so a frame
            // is always rendered with one level in one mode.
            if (frame_end) begin
                mode_q <= mode;
                if (pend_full) begin
                    active <= pending;
                end
            end

            if (transfer) begin
                pending   <= sample_in ^ MSB_MASK;
                pend_full <= 1'b1;
            end else if (frame_end) begin
                pend_full <= 1'b0;
            end

            dac_out <= (mode_q == MODE_SD) ? sd_bit : (cnt < active);
        end
    end

endmodule
